// File: rtl/motoro3_pkg.sv
// Shared types and constants for the 12-step sine PWM step sequencer.
// Holds the FSM encoding, the step/split limits and the split-count decode.
package motoro3_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] STEP_LAST       = 4'd11;
  localparam logic [1:0] SPLIT_FIRST     = 2'd3;
  localparam logic [3:0] HALF_SPLIT_STEP = 4'd5;

  // The split index counts down from SPLIT_FIRST to this value: 1, 2 or 4 splits.
  function automatic logic [1:0] split_end_decode(input logic [1:0] split_max);
    logic [1:0] split_end;
    case (split_max)
      2'd0:    split_end = 2'd3;
      2'd1:    split_end = 2'd2;
      default: split_end = 2'd0;
    endcase
    return split_end;
  endfunction

endpackage

// File: rtl/motoro3_pwm_duty_scaler.sv
// Scales the sine length into a duty count once per sub-period and compares
// the running sub-period counter against it.
module motoro3_pwm_duty_scaler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [15:0]      sl_len,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] cnt,
  output logic             active
);

  logic [CNT_W+15:0] product;
  logic [CNT_W-1:0]  duty_d;
  logic [CNT_W-1:0]  duty_q;

  // NOTE: every signal written in always_comb gets a value on every path,
  // starting with a default, so no latch is inferred.
  always_comb begin
    product = {{CNT_W{1'b0}}, sl_len} * {16'd0, period};
    duty_d  = duty_q;
    if (load) begin
      duty_d = product[CNT_W+15:16];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  // cnt 0 is always low, so the high time is exactly duty clocks.
  assign active = (cnt != '0) && (cnt <= duty_q);

endmodule

// File: rtl/motoro3_sine_pwm_step_sequencer.sv
// Walks the 12-step sine lookup address (step, split) and emits one PWM pulse
// per sub-period on the positive (steps 0-5) or negative (steps 6-11) output.
module motoro3_sine_pwm_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       m3r_stepSplitMax,
  input  logic [CNT_W-1:0] m3r_pwmPeriod,
  input  logic [15:0]      slLen,
  output logic [3:0]       lcStep,
  output logic [1:0]       m3LpwmSplitStep,
  output logic             pwmP,
  output logic             pwmN,
  output logic             stepEnd,
  output logic             cycleEnd,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [1:0]       split_q, split_d;
  logic [1:0]       split_end_q, split_end_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;

  logic [CNT_W-1:0] period_clamped;
  logic             run;
  logic             sub_last;
  logic             last_split;
  logic             step_done;
  logic             cycle_done;
  logic             active;

  assign period_clamped = (m3r_pwmPeriod < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD)
                                                                : m3r_pwmPeriod;
  assign run        = (state_q == ST_RUN);
  assign sub_last   = run && (cnt_q == period_q - CNT_W'(1));
  assign last_split = (split_q == split_end_q);
  assign step_done  = sub_last && last_split;
  assign cycle_done = step_done && (step_q == STEP_LAST);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    split_d     = split_q;
    split_end_d = split_end_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d     = ST_RUN;
          period_d    = period_clamped;
          split_end_d = split_end_decode(m3r_stepSplitMax);
          cnt_d       = '0;
          step_d      = '0;
          split_d     = SPLIT_FIRST;
        end
      end
      ST_RUN: begin
        if (sub_last) begin
          cnt_d = '0;
          if (last_split) begin
            // Split count is only re-read at a step boundary, period only at a cycle boundary.
            split_d     = SPLIT_FIRST;
            split_end_d = split_end_decode(m3r_stepSplitMax);
            step_d      = (step_q == STEP_LAST) ? 4'd0 : step_q + 4'd1;
            if (step_q == STEP_LAST) begin
              period_d = period_clamped;
            end
          end else begin
            split_d = split_q - 2'd1;
          end
          if (!en) begin
            state_d = ST_IDLE;
            step_d  = '0;
            split_d = SPLIT_FIRST;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      split_q     <= SPLIT_FIRST;
      split_end_q <= SPLIT_FIRST;
      cnt_q       <= '0;
      period_q    <= CNT_W'(MIN_PERIOD);
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      split_q     <= split_d;
      split_end_q <= split_end_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
    end
  end

  // Duty is captured on the cnt==0 edge from the lookup of the current address.
  motoro3_pwm_duty_scaler #(
    .CNT_W (CNT_W)
  ) u_duty_scaler (
    .clk    (clk),
    .rst    (rst),
    .load   (run && (cnt_q == '0)),
    .sl_len (slLen),
    .period (period_q),
    .cnt    (cnt_q),
    .active (active)
  );

  assign lcStep          = step_q;
  assign m3LpwmSplitStep = split_q;
  assign pwmP            = run && active && (step_q <= HALF_SPLIT_STEP);
  assign pwmN            = run && active && (step_q > HALF_SPLIT_STEP);
  assign stepEnd         = step_done;
  assign cycleEnd        = cycle_done;
  assign busy            = run;

endmodule

// File: tb/tb_motoro3_sine_pwm_step_sequencer.sv
// Self-checking bench: a time-within-step reference model checked every cycle,
// plus literal duty/interval expectations for the directed scenarios.
module tb_motoro3_sine_pwm_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  ssm;
  logic [15:0] period;
  logic [15:0] sl_len;
  logic [3:0]  lc_step;
  logic [1:0]  split;
  logic        pwm_p, pwm_n, step_end, cycle_end, busy;

  logic [15:0] lut [12][4];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // The sine lookup lives outside the DUT and answers combinationally.
  always_comb begin
    sl_len = 16'd0;
    if (lc_step < 4'd12) sl_len = lut[lc_step][split];
  end

  motoro3_sine_pwm_step_sequencer #(.CNT_W(16), .MIN_PERIOD(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .m3r_stepSplitMax (ssm),
    .m3r_pwmPeriod    (period),
    .slLen            (sl_len),
    .lcStep           (lc_step),
    .m3LpwmSplitStep  (split),
    .pwmP             (pwm_p),
    .pwmN             (pwm_n),
    .stepEnd          (step_end),
    .cycleEnd         (cycle_end),
    .busy             (busy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: position in time since the start of the current step.
  bit     m_valid = 1'b0;
  bit     m_run   = 1'b0;
  longint m_step  = 0;
  longint m_ts    = 0;
  longint m_p     = 2;
  longint m_s     = 1;
  longint m_duty  = 0;

  function automatic longint clamp_p(longint p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic longint splits_of(longint s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_step  = 0;
      m_ts    = 0;
      m_duty  = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run  = 1'b1;
        m_p    = clamp_p(longint'(period));
        m_s    = splits_of(longint'(ssm));
        m_step = 0;
        m_ts   = 0;
      end
    end else begin
      if (m_ts % m_p == 0)
        m_duty = (longint'(lut[int'(m_step)][int'(3 - m_ts / m_p)]) * m_p) >> 16;
      if (m_ts % m_p == m_p - 1) begin
        if (m_ts == m_s * m_p - 1) begin
          if (m_step == 11) begin
            m_step = 0;
            m_p    = clamp_p(longint'(period));
          end else begin
            m_step = m_step + 1;
          end
          m_s  = splits_of(longint'(ssm));
          m_ts = 0;
        end else begin
          m_ts = m_ts + 1;
        end
        if (!en) begin
          m_run  = 1'b0;
          m_step = 0;
          m_ts   = 0;
        end
      end else begin
        m_ts = m_ts + 1;
      end
    end
  end

  // One compare per cycle of the full output vector against the model.
  always @(negedge clk) begin
    logic [10:0] exp_v;
    logic [10:0] act_v;
    longint c;
    bit hi, se, ce;
    if (m_valid) begin
      exp_v = {1'b0, 4'd0, 2'd3, 4'b0000};
      if (m_run) begin
        c  = m_ts % m_p;
        hi = (c >= 1) && (c <= m_duty);
        se = (m_ts == m_s * m_p - 1);
        ce = se && (m_step == 11);
        exp_v = {1'b1, 4'(m_step), 2'(3 - m_ts / m_p),
                 hi && (m_step <= 5), hi && (m_step > 5), se, ce};
      end
      act_v = {busy, lc_step, split, pwm_p, pwm_n, step_end, cycle_end};
      check("model_vector", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic wait_addr(input int s, input int sp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (busy && lc_step == 4'(s) && split == 2'(sp)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic measure_high(input string name, input int s, input int sp,
                              input int exp_p, input int exp_n);
    bit ok;
    int np, nn, guard;
    wait_addr(s, sp, ok);
    check({name, "_found"}, 32'(ok), 32'd1);
    np = 0; nn = 0; guard = 0;
    while (ok && busy && lc_step == 4'(s) && split == 2'(sp) && guard < 70000) begin
      np += int'(pwm_p);
      nn += int'(pwm_n);
      @(negedge clk);
      guard++;
    end
    check({name, "_p_high"}, 32'(np), 32'(exp_p));
    check({name, "_n_high"}, 32'(nn), 32'(exp_n));
  endtask

  function automatic bit pulse_of(input bit which);
    return which ? cycle_end : step_end;
  endfunction

  task automatic wait_pulse(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (pulse_of(which)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_to_pulse(input string name, input bit which, input int expected);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pulse_of(which) && n < 20000);
    check(name, 32'(n), 32'(expected));
  endtask

  task automatic gap(input string name, input bit which, input int expected);
    bit ok;
    wait_pulse(which, ok);
    check({name, "_found"}, 32'(ok), 32'd1);
    count_to_pulse(name, which, expected);
  endtask

  task automatic stop_run();
    int n;
    en  = 1'b0;
    rst = 1'b0;
    n   = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("stop_reaches_idle", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int n, se;
    rst    = 1'b1;
    en     = 1'b0;
    ssm    = 2'd0;
    period = 16'd100;
    for (int s = 0; s < 12; s++)
      for (int sp = 0; sp < 4; sp++)
        lut[s][sp] = 16'($urandom);

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_step", 32'(lc_step), 32'd0);
    check("idle_split", 32'(split), 32'd3);
    check("idle_pwm", 32'({pwm_p, pwm_n}), 32'd0);

    // One split per step, period 100.
    lut[0][3] = 16'd17560;
    lut[2][3] = 16'd65535;
    lut[7][3] = 16'd65535;
    en = 1'b1;
    measure_high("basic_s0", 0, 3, 26, 0);
    measure_high("basic_s2", 2, 3, 99, 0);
    measure_high("basic_s7", 7, 3, 0, 99);
    gap("basic_cycle_len", 1'b1, 1200);

    // Four splits per step.
    stop_run();
    ssm = 2'd2;
    lut[0][3] = 16'd4287;
    lut[0][2] = 16'd12785;
    lut[0][1] = 16'd21065;
    lut[0][0] = 16'd28987;
    en = 1'b1;
    measure_high("four_sp3", 0, 3, 6, 0);
    measure_high("four_sp2", 0, 2, 19, 0);
    measure_high("four_sp1", 0, 1, 32, 0);
    measure_high("four_sp0", 0, 0, 44, 0);
    gap("four_step_len", 1'b0, 400);
    gap("four_cycle_len", 1'b1, 4800);

    // Period clamp.
    stop_run();
    ssm = 2'd0;
    period = 16'd1;
    en = 1'b1;
    measure_high("clamp_s2", 2, 3, 1, 0);
    gap("clamp_step_len", 1'b0, 2);

    // Period change mid-cycle applies after cycleEnd only.
    stop_run();
    period = 16'd100;
    en = 1'b1;
    wait_pulse(1'b1, ok);
    check("bnd_first_cycle_found", 32'(ok), 32'd1);
    repeat (300) @(negedge clk);
    period = 16'd200;
    count_to_pulse("bnd_old_period_rest", 1'b1, 900);
    gap("bnd_new_period_cycle", 1'b1, 2400);

    // Split count change mid-step applies from the next step.
    wait_pulse(1'b0, ok);
    repeat (30) @(negedge clk);
    ssm = 2'd1;
    count_to_pulse("bnd_old_split_rest", 1'b0, 170);
    count_to_pulse("bnd_new_split_step", 1'b0, 400);

    // Stop mid sub-period with four splits: no step end.
    stop_run();
    period = 16'd100;
    ssm = 2'd2;
    en = 1'b1;
    wait_addr(4, 3, ok);
    check("stop_found", 32'(ok), 32'd1);
    repeat (50) @(negedge clk);
    en = 1'b0;
    n = 0; se = 0;
    while (busy && n < 1000) begin
      se += int'(step_end);
      @(negedge clk);
      n++;
    end
    check("stop_tail_len", 32'(n), 32'd50);
    check("stop_no_step_end", 32'(se), 32'd0);
    check("stop_step", 32'(lc_step), 32'd0);
    check("stop_split", 32'(split), 32'd3);

    // Reset mid-pulse.
    en = 1'b1;
    n = 0;
    while (!pwm_p && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rst_pulse_seen", 32'(pwm_p), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", 32'({busy, pwm_p, pwm_n, step_end, cycle_end}), 32'd0);
    check("rst_addr", 32'({lc_step, split}), 32'({4'd0, 2'd3}));
    rst = 1'b0;
    @(negedge clk);
    check("rst_restart", 32'({busy, lc_step}), 32'({1'b1, 4'd0}));

    // Randomized runs with boundary-timed control changes.
    for (int seg = 0; seg < 30; seg++) begin
      stop_run();
      for (int s = 0; s < 12; s++)
        for (int sp = 0; sp < 4; sp++)
          lut[s][sp] = 16'($urandom);
      period = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 1))
                                           : 16'($urandom_range(2, 24));
      ssm = 2'($urandom_range(0, 3));
      en  = 1'b1;
      n   = int'($urandom_range(100, 600));
      for (int i = 0; i < n; i++) begin
        int r;
        @(negedge clk);
        r = int'($urandom_range(0, 199));
        rst = 1'b0;
        if (r == 0)      period = 16'($urandom_range(2, 24));
        else if (r == 1) ssm = 2'($urandom_range(0, 3));
        else if (r == 2) en = 1'b0;
        else if (r == 3) en = 1'b1;
        else if (r == 4) rst = 1'b1;
      end
      rst = 1'b0;
    end
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motoro3_sine_pwm_step_sequencer.md
Name: motoro3_sine_pwm_step_sequencer

Overview:
Drives the 12-step sine PWM lookup and consumes its result.
- Walks the step index lcStep (0..11) and the split index m3LpwmSplitStep within each step.
- Samples the returned slLen and scales it against a programmable sub-period.
- Emits one PWM pulse per sub-period on the positive-half output (steps 0-5) or the negative-half output (steps 6-11).
- Sits between motor control registers and the phase gate drivers.

Parameters:
- CNT_W, 16, width of the sub-period counter, period register and duty register.
- MIN_PERIOD, 2, smallest honoured sub-period; smaller programmed values are clamped up to this.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- m3r_stepSplitMax  in  2  splits per step: 0 gives 1, 1 gives 2, 2 or 3 gives 4.
- m3r_pwmPeriod  in  CNT_W  sub-period length in clk cycles.
- slLen  in  16  sine length returned by the lookup for the current lcStep/m3LpwmSplitStep; combinational, same cycle.
- lcStep  out  4  step address to the lookup.
- m3LpwmSplitStep  out  2  split address to the lookup.
- pwmP  out  1  PWM for the positive half, steps 0-5.
- pwmN  out  1  PWM for the negative half, steps 6-11.
- stepEnd  out  1  one-cycle pulse on the last clock of a step's final split.
- cycleEnd  out  1  one-cycle pulse on the last clock of step 11.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FSM=IDLE, lcStep=0, m3LpwmSplitStep=3, cnt=0, duty=0, pwmP=pwmN=stepEnd=cycleEnd=busy=0. Reset mid-run aborts immediately with no pulse completion.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when en=1. On that edge: periodReg = max(m3r_pwmPeriod, MIN_PERIOD); splitEnd latched; cnt=0.
- splitEnd mapping: m3r_stepSplitMax 0 -> 3, 1 -> 2, 2 or 3 -> 0.
  - Split index counts down from 3 to splitEnd, so 1, 2 or 4 sub-periods per step.
- RUN, sub-period of periodReg cycles, cnt 0..periodReg-1:
  - At cnt==0: duty = (slLen * periodReg) >> 16, 32-bit product, upper 16 bits kept. slLen is taken from the current address.
  - Active output is high when cnt>=1 and cnt<=duty. High time is exactly duty clocks; cnt 0 is always low. duty <= periodReg-1 always.
  - Active output is pwmP when lcStep<=5, else pwmN. The inactive output is held 0.
  - At cnt==periodReg-1: cnt wraps to 0 and the address advances, visible to the lookup on the next cycle:
    - if split != splitEnd: split--.
    - else: split=3, stepEnd=1, lcStep = (lcStep==11) ? 0 : lcStep+1. splitEnd is re-latched from m3r_stepSplitMax at this point.
    - if also lcStep==11: cycleEnd=1, and periodReg is re-latched (clamped).
- m3r_stepSplitMax and m3r_pwmPeriod changes take effect only at the boundaries above, never mid-step or mid-cycle.
- en=0 during RUN: the current sub-period completes. At its last cycle the FSM goes to IDLE with lcStep=0, split=3, outputs 0. No stepEnd/cycleEnd unless that cycle is genuinely a step/cycle end.
- en=1 again on the IDLE cycle restarts from step 0.
- busy=1 for every cycle in RUN.
- Electrical cycle length = 12 * splitsPerStep * periodReg clocks.

Decomposition:
- Shared package motoro3_pkg: FSM state enum, STEP_LAST=11, SPLIT_FIRST=3, HALF_SPLIT_STEP=5, and the splitEnd decode function.
- One sub-module: motoro3_pwm_duty_scaler, the registered 16x16 multiply plus >>16 plus compare of cnt against duty.
- The lookup instance stays outside this block, at the top level.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then en=0 -> lcStep=0, split=3, pwmP=pwmN=busy=0 held.
- Basic: en=1, stepSplitMax=0, period=100, real lookup -> step 0 duty 26 (17560*100>>16); step 2 duty 99; pwmP used on steps 0-5, pwmN on 6-11; cycleEnd every 1200 clocks.
- Four splits: stepSplitMax=2, period=100 -> step 0 splits 3,2,1,0 give duties 6,19,32,44; stepEnd every 400 clocks; cycleEnd every 4800.
- Clamp: period=1 -> periodReg=2; at step 2 duty=1, i.e. high on cnt 1 only.
- Boundary updates: change period 100->200 mid-cycle -> new length applies only after cycleEnd. Change stepSplitMax 0->1 mid-step -> splits 3,2 start at the next step.
- Stop/reset: en=0 at cnt 50 of step 4 -> IDLE after cnt 99, outputs 0, no stepEnd. Separately, rst=1 mid-pulse -> all outputs 0 on the next clock, restart from step 0.
